// File: rtl/latmem_pkg.sv
// Shared definitions for the latmem memory model: LFSR polynomial, default seed and
// read-latency bound.
package latmem_pkg;

  typedef logic [15:0] lfsr_t;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam lfsr_t LfsrTaps = 16'hB400;
  localparam lfsr_t LfsrDefaultSeed = 16'hACE1;
  localparam int unsigned RdLatMax = 16;

  function automatic lfsr_t lfsr_next(input lfsr_t s);
    return {s[14:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/latmem_lfsr16.sv
// 16-bit Fibonacci LFSR that advances every cycle; reusable by other stress models.
module latmem_lfsr16
  import latmem_pkg::*;
#(
  parameter lfsr_t Seed = LfsrDefaultSeed
) (
  input  logic  clk,
  input  logic  reset_n,
  output lfsr_t state
);

  lfsr_t state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= Seed;
    end else begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/latmem.sv
// Main-memory model with byte-lane writes, pipelined in-order reads of configurable latency
// and optional LFSR-driven back-pressure on mem_ready.
module latmem
  import latmem_pkg::*;
#(
  parameter int unsigned ADDRBITS  = 10,
  parameter int unsigned DATABITS  = 32,
  parameter int unsigned RDLAT     = 1,
  parameter bit          STALL_EN  = 1'b0,
  parameter int unsigned STALLBITS = 3,
  parameter lfsr_t       LFSR_SEED = LfsrDefaultSeed
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDRBITS-1:0]   mem_addr,
  input  logic [DATABITS-1:0]   mem_in,
  input  logic [DATABITS/8-1:0] mem_be,
  input  logic                  mem_wrreq,
  input  logic                  mem_rdreq,
  output logic                  mem_ready,
  output logic [DATABITS-1:0]   mem_out,
  output logic                  mem_out_valid
);

  localparam int unsigned Depth = 2 ** ADDRBITS;
  localparam int unsigned Lanes = DATABITS / 8;
  localparam lfsr_t StallMask = lfsr_t'((17'd1 << STALLBITS) - 17'd1);

  if (DATABITS == 0 || DATABITS % 8 != 0) begin : g_bad_databits
    $error("latmem: DATABITS must be a non-zero multiple of 8");
  end
  if (RDLAT < 1 || RDLAT > RdLatMax) begin : g_bad_rdlat
    $error("latmem: RDLAT must be within 1..16");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("latmem: LFSR_SEED must be non-zero");
  end
  if (STALLBITS < 1 || STALLBITS > 16) begin : g_bad_stallbits
    $error("latmem: STALLBITS must be within 1..16");
  end

  lfsr_t lfsr_state;

  latmem_lfsr16 #(
    .Seed (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (lfsr_state)
  );

  assign mem_ready = !(STALL_EN && ((lfsr_state & StallMask) == '0));

  logic wr_acc;
  logic rd_acc;

  // A simultaneous read is dropped: the write owns the cycle.
  assign wr_acc = mem_ready & mem_wrreq;
  assign rd_acc = mem_ready & mem_rdreq & ~mem_wrreq;

  logic [DATABITS-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < Lanes; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_addr][8*i +: 8] <= mem_in[8*i +: 8];
        end
      end
    end
  end

  logic [RDLAT-1:0]    vld_q;
  logic [DATABITS-1:0] dat_q [RDLAT];

  // Data only advances behind a valid token, so the last stage holds between results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int s = 0; s < RDLAT; s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) begin
        dat_q[0] <= mem_q[mem_addr];
      end
      for (int s = 1; s < RDLAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          dat_q[s] <= dat_q[s-1];
        end
      end
    end
  end

  assign mem_out_valid = vld_q[RDLAT-1];
  assign mem_out       = dat_q[RDLAT-1];

endmodule
